// File: rtl/cpu_pkg.sv
// Shared RV32I core definitions: control-word bit positions, opcodes, and the control struct.
// Bit layout matches the decoder output {alusrc, memtoreg, regwrite, memread, memwrite, branch, alu_op}.
package cpu_pkg;

    localparam int CTRL_ALUSRC   = 7;
    localparam int CTRL_MEMTOREG = 6;
    localparam int CTRL_REGWRITE = 5;
    localparam int CTRL_MEMREAD  = 4;
    localparam int CTRL_MEMWRITE = 3;
    localparam int CTRL_BRANCH   = 2;
    localparam int CTRL_ALUOP_HI = 1;
    localparam int CTRL_ALUOP_LO = 0;

    localparam logic [7:0] CTRL_BUBBLE = 8'h00;

    localparam logic [6:0] OP_RTYPE  = 7'b0110011;
    localparam logic [6:0] OP_ITYPE  = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    typedef struct packed {
        logic       alusrc;
        logic       memtoreg;
        logic       regwrite;
        logic       memread;
        logic       memwrite;
        logic       branch;
        logic [1:0] alu_op;
    } ctrl_t;

    // rs2 is read by R-type/branch (register operand) and by stores (store data).
    function automatic logic rs2_used(input logic [7:0] ctrl);
        return (~ctrl[CTRL_ALUSRC] & (ctrl != CTRL_BUBBLE)) | ctrl[CTRL_MEMWRITE];
    endfunction

endpackage

// File: rtl/loaduse_detect.sv
// Load-use hazard detector: flags an ID instruction that reads the destination of a load in EX.
// Purely combinational; x0 destinations and invalid slots never raise a hazard.
module loaduse_detect
    import cpu_pkg::*;
(
    input  logic [7:0] ctrl_id,
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       valid_id,
    input  logic       valid_ex,
    input  logic       memread_ex,
    input  logic [4:0] rd_ex,
    output logic       hazard
);

    logic rs1_hit;
    logic rs2_hit;

    assign rs1_hit = (rd_ex == rs1_id) && (ctrl_id != CTRL_BUBBLE);
    assign rs2_hit = (rd_ex == rs2_id) && rs2_used(ctrl_id);

    assign hazard = valid_id & valid_ex & memread_ex & (rd_ex != 5'd0) & (rs1_hit | rs2_hit);

endmodule

// File: rtl/id_ex_stage.sv
// ID/EX pipeline register with load-use bubble insertion, flush/stall handling and a saturating bubble counter.
// Hazard logic and bubble_cnt exist only when LOADUSE_DETECT_EN is defined; otherwise stall_id follows stall_ext.
module id_ex_stage
    import cpu_pkg::*;
#(
    parameter int XLEN  = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [7:0]       ctrl_id,
    input  logic             valid_id,
    input  logic [XLEN-1:0]  pc_id,
    input  logic [XLEN-1:0]  rs1_data_id,
    input  logic [XLEN-1:0]  rs2_data_id,
    input  logic [XLEN-1:0]  imm_id,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic [4:0]       rd_id,
    input  logic [2:0]       funct3_id,
    input  logic             funct7b5_id,
    input  logic             stall_ext,
    input  logic             flush,
    output logic             alusrc_ex,
    output logic             memtoreg_ex,
    output logic             regwrite_ex,
    output logic             memread_ex,
    output logic             memwrite_ex,
    output logic             branch_ex,
    output logic [1:0]       alu_op_ex,
    output logic             valid_ex,
    output logic [XLEN-1:0]  pc_ex,
    output logic [XLEN-1:0]  rs1_data_ex,
    output logic [XLEN-1:0]  rs2_data_ex,
    output logic [XLEN-1:0]  imm_ex,
    output logic [4:0]       rs1_ex,
    output logic [4:0]       rs2_ex,
    output logic [4:0]       rd_ex,
    output logic [2:0]       funct3_ex,
    output logic             funct7b5_ex,
    output logic             stall_id,
    output logic [CNT_W-1:0] bubble_cnt
);

    ctrl_t            ctrl_q;
    logic             valid_q;
    logic [XLEN-1:0]  pc_q, rs1_data_q, rs2_data_q, imm_q;
    logic [4:0]       rs1_q, rs2_q, rd_q;
    logic [2:0]       funct3_q;
    logic             funct7b5_q;
    logic             hazard;
    logic             load_bubble;
    logic             hold;

`ifdef LOADUSE_DETECT_EN
    logic [CNT_W-1:0] cnt_q;

    loaduse_detect u_loaduse_detect (
        .ctrl_id    (ctrl_id),
        .rs1_id     (rs1_id),
        .rs2_id     (rs2_id),
        .valid_id   (valid_id),
        .valid_ex   (valid_q),
        .memread_ex (ctrl_q.memread),
        .rd_ex      (rd_q),
        .hazard     (hazard)
    );

    // Only load-use bubbles count; flush and external stall take precedence over the hazard.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (!flush && !stall_ext && hazard && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    assign bubble_cnt = cnt_q;
`else
    assign hazard     = 1'b0;
    assign bubble_cnt = '0;
`endif

    // Flush beats stall_ext, which beats the load-use hazard.
    assign load_bubble = flush | (~stall_ext & hazard);
    assign hold        = ~flush & stall_ext;
    assign stall_id    = stall_ext | (hazard & ~flush);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n || load_bubble) begin
            ctrl_q     <= ctrl_t'(CTRL_BUBBLE);
            valid_q    <= 1'b0;
            pc_q       <= '0;
            rs1_data_q <= '0;
            rs2_data_q <= '0;
            imm_q      <= '0;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            funct3_q   <= '0;
            funct7b5_q <= 1'b0;
        end else if (!hold) begin
            ctrl_q     <= valid_id ? ctrl_t'(ctrl_id) : ctrl_t'(CTRL_BUBBLE);
            valid_q    <= valid_id;
            pc_q       <= pc_id;
            rs1_data_q <= rs1_data_id;
            rs2_data_q <= rs2_data_id;
            imm_q      <= imm_id;
            rs1_q      <= rs1_id;
            rs2_q      <= rs2_id;
            rd_q       <= rd_id;
            funct3_q   <= funct3_id;
            funct7b5_q <= funct7b5_id;
        end
    end

    assign alusrc_ex   = ctrl_q.alusrc;
    assign memtoreg_ex = ctrl_q.memtoreg;
    assign regwrite_ex = ctrl_q.regwrite;
    assign memread_ex  = ctrl_q.memread;
    assign memwrite_ex = ctrl_q.memwrite;
    assign branch_ex   = ctrl_q.branch;
    assign alu_op_ex   = ctrl_q.alu_op;
    assign valid_ex    = valid_q;
    assign pc_ex       = pc_q;
    assign rs1_data_ex = rs1_data_q;
    assign rs2_data_ex = rs2_data_q;
    assign imm_ex      = imm_q;
    assign rs1_ex      = rs1_q;
    assign rs2_ex      = rs2_q;
    assign rd_ex       = rd_q;
    assign funct3_ex   = funct3_q;
    assign funct7b5_ex = funct7b5_q;

endmodule

// File: doc/id_ex_stage.md
# id_ex_stage

ID/EX pipeline register of the RV32I core. It sits directly downstream of the control unit and its control-word decoder. Each cycle it captures the 8-bit control word and the decoded operands of the instruction in ID, and presents them as registered fields to EX. It also detects load-use hazards, inserts bubbles, honours downstream stalls and branch flushes, and counts inserted bubbles.

## Interface
Parameters:
- XLEN, 32, datapath width
- CNT_W, 16, width of bubble counter

Ports:
- clk  in  1  core clock
- rst_n  in  1  asynchronous, active-low reset
- ctrl_id  in  8  control word {alusrc, memtoreg, regwrite, memread, memwrite, branch, alu_op[1:0]}
- valid_id  in  1  ID holds a real instruction
- pc_id  in  XLEN  instruction PC
- rs1_data_id, rs2_data_id  in  XLEN  register-file read data
- imm_id  in  XLEN  sign-extended immediate
- rs1_id, rs2_id, rd_id  in  5  register indices
- funct3_id  in  3; funct7b5_id  in  1  ALU-control inputs
- stall_ext  in  1  downstream (memory) wait; hold EX contents
- flush  in  1  branch taken in EX; kill instruction entering EX
- alusrc_ex, memtoreg_ex, regwrite_ex, memread_ex, memwrite_ex, branch_ex  out  1  registered control fields
- alu_op_ex  out  2
- valid_ex  out  1
- pc_ex, rs1_data_ex, rs2_data_ex, imm_ex  out  XLEN
- rs1_ex, rs2_ex, rd_ex  out  5; funct3_ex  out  3; funct7b5_ex  out  1
- stall_id  out  1  hold PC and IF/ID register (combinational)
- bubble_cnt  out  CNT_W  load-use bubbles inserted, saturating

## Operation
- Bubble: all control outputs are 0 and valid_ex is 0. Datapath outputs are don't-care but are driven to 0.
- The register update at each rising edge follows this priority (first match wins):
  1. flush: load bubble.
  2. stall_ext: hold all EX registers unchanged.
  3. hazard: load bubble; bubble_cnt increments.
  4. Otherwise: capture all *_id inputs. If valid_id=0, ctrl is forced to 0.
- Hazard condition (load-use): valid_ex & memread_ex & rd_ex≠0, together with either of:
  - rd_ex==rs1_id with ctrl_id≠0 (rs1 used), or
  - rd_ex==rs2_id with rs2 used (ctrl_id[7]==0 & ctrl_id≠0, or ctrl_id[3]==1).
  - Hazard is additionally gated by valid_id.
- stall_id = stall_ext | (hazard & ~flush).
- A load-use stall lasts exactly one cycle: after the bubble, valid_ex=0, so the hazard clears.
- bubble_cnt saturates at all-ones and never wraps. Flush bubbles and stall holds are not counted.
- flush together with stall_ext: flush wins. EX gets a bubble and stall_id=1 for that cycle.
- x0 destination never causes a hazard.

## Timing
- All EX outputs are registered, with 1-cycle latency from *_id inputs.
- stall_id is combinational from ctrl_id, rs*_id, valid_id, EX registers, stall_ext and flush. It has no dependency on clk.
- Reset (rst_n=0, asynchronous): all outputs registered to 0, bubble_cnt=0. stall_id then equals stall_ext.
- Reset deassertion mid-stream: the first capture occurs at the first rising edge with rst_n=1.
- Reset asserted mid-hazard discards the pending stall. No state survives.

## Configuration
- LOADUSE_DETECT_EN defined: hazard detection, bubble insertion and bubble_cnt are present as described.
- Not defined: hazard is tied to 0, so stall_id = stall_ext and bubble_cnt is tied to 0. The core then relies on compiler-scheduled load delay slots.

## Structure
- Shared package cpu_pkg holds:
  - control-word bit index constants: CTRL_ALUSRC=7, CTRL_MEMTOREG=6, CTRL_REGWRITE=5, CTRL_MEMREAD=4, CTRL_MEMWRITE=3, CTRL_BRANCH=2, CTRL_ALUOP=1:0
  - CTRL_BUBBLE=8'h00
  - the five opcode constants
  - a ctrl_t packed struct
- One sub-module, loaduse_detect, purely combinational. It takes ctrl_id, rs1_id, rs2_id, valid_id, valid_ex, memread_ex and rd_ex, and outputs hazard. It is instantiated only under LOADUSE_DETECT_EN.

## Test plan
- Reset: rst_n=0 asynchronously mid-cycle -> all outputs 0 immediately, bubble_cnt=0.
- Pass-through: ctrl_id=8'b00100010 (R-type), rd_id=5 -> next edge regwrite_ex=1, alu_op_ex=2'b10, rd_ex=5, valid_ex=1.
- Load-use: load (ctrl 8'b11110000, rd=7) in EX, add with rs2_id=7 in ID -> stall_id=1 for one cycle, then a bubble in EX, bubble_cnt=1. The add is captured on the following edge.
- No false hazard:
  - load rd=0 followed by a user of x0 -> stall_id=0.
  - I-type (ctrl 8'b10100010) with rs2_id==rd_ex -> stall_id=0.
- Flush vs stall: flush=1 and stall_ext=1 in the same cycle -> EX becomes a bubble and stall_id=1. With flush=0 and stall_ext=1 for 3 cycles -> EX held unchanged for 3 cycles.
- Saturation: force 2^CNT_W+2 load-use events -> bubble_cnt holds 16'hFFFF.
